// File: rtl/obst_pkg.sv
// Shared types, seed pattern, lane-to-row map and tick period helper for obstacle_field.
package obst_pkg;

    typedef enum logic [1:0] {
        EASY   = 2'd0,
        MEDIUM = 2'd1,
        HARD   = 2'd2,
        PAUSE  = 2'd3
    } level_t;

    localparam logic [15:0] OBST_BASE = 16'hC318;
    localparam logic [4:0]  NO_LANE   = 5'h1F;

    // Indexed [level][row]; each entry is the lane driving that row, row 0 at the bottom.
    localparam logic [4:0] LANE_MAP [3][16] = '{
        '{NO_LANE, 5'd6, NO_LANE, 5'd5, NO_LANE, 5'd4, NO_LANE, 5'd3,
          NO_LANE, 5'd2, NO_LANE, 5'd1, NO_LANE, 5'd0, NO_LANE, NO_LANE},
        '{NO_LANE, 5'd8, 5'd7, NO_LANE, 5'd6, NO_LANE, 5'd5, 5'd4,
          NO_LANE, 5'd3, NO_LANE, 5'd2, NO_LANE, 5'd1, 5'd0, NO_LANE},
        '{NO_LANE, 5'd9, 5'd8, 5'd7, 5'd6, NO_LANE, 5'd5, 5'd4,
          NO_LANE, 5'd3, NO_LANE, 5'd2, NO_LANE, 5'd1, 5'd0, NO_LANE}
    };

    // Easier levels get longer periods: one extra step per level below HARD.
    function automatic logic [31:0] tick_period(input level_t lvl,
                                                input logic [31:0] base,
                                                input logic [31:0] step);
        case (lvl)
            EASY:    return base + (step << 1);
            MEDIUM:  return base + step;
            default: return base;
        endcase
    endfunction

endpackage

// File: rtl/obst_lane.sv
// One circular obstacle lane: seeded on reset/reseed, rotates one column per selected tick.
// Optional OBST_REVERSE_EN resamples direction after every full revolution.
module obst_lane
    import obst_pkg::*;
#(
    parameter int COLS = 16,
    parameter int ROT  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            reseed,
    input  logic            hold,
    input  logic            fast_tick,
    input  logic            slow_tick,
    input  logic            rand_bit,
    output logic [COLS-1:0] pattern
);

    localparam int              SHIFT = ROT % COLS;
    localparam logic [COLS-1:0] BASE  = OBST_BASE[COLS-1:0];
    localparam logic [COLS-1:0] SEED  = (SHIFT == 0) ? BASE
                                      : ((BASE >> SHIFT) | (BASE << (COLS - SHIFT)));

    logic dir;
    logic spd;
    logic step_en;

    assign step_en = !hold && (spd ? fast_tick : slow_tick);

`ifdef OBST_REVERSE_EN
    localparam int REV_W = (COLS > 1) ? $clog2(COLS) : 1;
    logic [REV_W-1:0] rev_cnt;

    always_ff @(posedge clk) begin
        if (reset || reseed) begin
            rev_cnt <= '0;
        end else if (step_en) begin
            rev_cnt <= (rev_cnt == REV_W'(COLS - 1)) ? '0 : rev_cnt + REV_W'(1);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset || reseed) begin
            pattern <= SEED;
            dir     <= rand_bit;
            spd     <= rand_bit;
        end else if (step_en) begin
            // dir = 1 moves bits toward the MSB (leftward on the matrix)
            pattern <= dir ? {pattern[COLS-2:0], pattern[COLS-1]}
                           : {pattern[0], pattern[COLS-1:1]};
`ifdef OBST_REVERSE_EN
            if (rev_cnt == REV_W'(COLS - 1)) begin
                dir <= rand_bit;
            end
`endif
        end
    end

endmodule

// File: rtl/obstacle_field.sv
// Obstacle-lane generator for the red LED plane; red is registered, one cycle behind lane shifts.
// No backpressure: win/loss freeze and level 3 pause hold state. Build option: OBST_REVERSE_EN.
module obstacle_field
    import obst_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int LANES      = 10,
    parameter int DIV_W      = 32,
    parameter int FAST_BASE  = 10000000,
    parameter int SLOW_BASE  = 15000000,
    parameter int LEVEL_STEP = 5000000,
    parameter int IDLE_LIMIT = 500000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 level,
    input  logic [LANES-1:0]           lane_rand,
    input  logic                       movement,
    input  logic                       win,
    input  logic                       loss,
    output logic [ROWS-1:0][COLS-1:0]  red,
    output logic                       timeout
);

    level_t                       level_in;
    level_t                       level_q;
    logic                         lvl_change;
    logic                         pause;
    logic                         hold;
    logic [DIV_W-1:0]             fast_cnt;
    logic [DIV_W-1:0]             slow_cnt;
    logic [DIV_W-1:0]             fast_period;
    logic [DIV_W-1:0]             slow_period;
    logic                         fast_tick;
    logic                         slow_tick;
    logic [DIV_W-1:0]             idle_cnt;
    logic                         idle_hit;
    logic                         timeout_next;
    logic [LANES-1:0][COLS-1:0]   lane_pat;
    logic [ROWS-1:0][COLS-1:0]    red_map;
    logic [1:0]                   map_sel;

    assign level_in   = level_t'(level);
    assign lvl_change = (level_in != level_q);
    assign pause      = (level_in == PAUSE);
    assign hold       = pause || win || loss;

    assign fast_period = DIV_W'(tick_period(level_q, 32'(FAST_BASE), 32'(LEVEL_STEP)));
    assign slow_period = DIV_W'(tick_period(level_q, 32'(SLOW_BASE), 32'(LEVEL_STEP)));
    assign fast_tick   = (fast_cnt == fast_period - DIV_W'(1));
    assign slow_tick   = (slow_cnt == slow_period - DIV_W'(1));

    always_ff @(posedge clk) begin
        level_q <= level_in;
        if (reset || lvl_change) begin
            fast_cnt <= '0;
            slow_cnt <= '0;
        end else if (!hold) begin
            fast_cnt <= fast_tick ? '0 : fast_cnt + DIV_W'(1);
            slow_cnt <= slow_tick ? '0 : slow_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        obst_lane #(
            .COLS (COLS),
            .ROT  (i + 1)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .reseed    (lvl_change),
            .hold      (hold),
            .fast_tick (fast_tick),
            .slow_tick (slow_tick),
            .rand_bit  (lane_rand[i]),
            .pattern   (lane_pat[i])
        );
    end

    assign idle_hit = (idle_cnt == DIV_W'(IDLE_LIMIT));

    // Movement beats a same-cycle limit hit, so the kill never fires while the player is active.
    always_comb begin
        timeout_next = timeout;
        if (lvl_change || movement) begin
            timeout_next = 1'b0;
        end else if (!hold && idle_hit) begin
            timeout_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= timeout_next;
            if (lvl_change || movement) begin
                idle_cnt <= '0;
            end else if (!hold && !idle_hit) begin
                idle_cnt <= idle_cnt + DIV_W'(1);
            end
        end
    end

    assign map_sel = (level_q == PAUSE) ? 2'd0 : 2'(level_q);

    always_comb begin
        logic [4:0] lane_idx;
        red_map  = '0;
        lane_idx = NO_LANE;
        for (int r = 0; r < ROWS; r++) begin
            lane_idx = LANE_MAP[map_sel][r];
            for (int l = 0; l < LANES; l++) begin
                if (level_q != PAUSE && lane_idx == 5'(l)) begin
                    red_map[r] = lane_pat[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            red <= '0;
        end else if (!pause) begin
            red <= timeout_next ? '1 : red_map;
        end
    end

endmodule

// File: tb/tb_obstacle_field.sv
// Directed bench for obstacle_field with shortened tick and idle periods.
module tb_obstacle_field;

    logic                  clk;
    logic                  reset;
    logic [1:0]            level;
    logic [9:0]            lane_rand;
    logic                  movement;
    logic                  win;
    logic                  loss;
    logic [15:0][15:0]     red;
    logic                  timeout;

    int checks   = 0;
    int failures = 0;

    obstacle_field #(
        .ROWS       (16),
        .COLS       (16),
        .LANES      (10),
        .DIV_W      (32),
        .FAST_BASE  (2),
        .SLOW_BASE  (3),
        .LEVEL_STEP (1),
        .IDLE_LIMIT (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .lane_rand (lane_rand),
        .movement  (movement),
        .win       (win),
        .loss      (loss),
        .red       (red),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] rev_exp;

    initial begin
`ifdef OBST_REVERSE_EN
        rev_exp = 16'h30C6;
`else
        rev_exp = 16'hC318;
`endif
        reset = 1'b1; level = 2'd0; lane_rand = '0;
        movement = 1'b0; win = 1'b0; loss = 1'b0;
        step(5);
        chk("reset_red", red, '0);
        chk("reset_timeout", timeout, 1'b0);

        reset = 1'b0;
        step(1);                                    // edge 1
        chk("seed_row13", red[13], 16'h618C);
        chk("seed_row11", red[11], 16'h30C6);
        chk("empty_row0", red[0], 16'h0000);
        chk("empty_row15", red[15], 16'h0000);
        chk("timeout_idle_start", timeout, 1'b0);
        step(4);                                    // edge 5
        chk("slow_pre_shift", red[13], 16'h618C);
        step(1);                                    // edge 6
        chk("slow_shift_right", red[13], 16'h30C6);

        lane_rand = 10'b00_0000_0001; level = 2'd2;
        step(2);                                    // edge 8
        chk("hard_row14_seed", red[14], 16'h618C);
        chk("hard_row3_lane7", red[3], 16'h18C3);
        chk("hard_row15_empty", red[15], 16'h0000);
        step(2);                                    // edge 10
        chk("fast_left_1", red[14], 16'hC318);
        step(2);                                    // edge 12
        chk("fast_left_2", red[14], 16'h8631);

        step(45);                                   // edge 57
        chk("timeout_before_limit", timeout, 1'b0);
        step(1);                                    // edge 58
        chk("timeout_set", timeout, 1'b1);
        chk("kill_all_ones", red, {256{1'b1}});

        movement = 1'b1;
        step(1);                                    // edge 59
        chk("timeout_cleared", timeout, 1'b0);
        chk("map_restored_row14", red[14], 16'h18C3);
        chk("map_restored_row15", red[15], 16'h0000);
        movement = 1'b0; win = 1'b1;

        step(1);                                    // edge 60
        chk("freeze_start", red[14], 16'h3186);
        step(19);                                   // edge 79
        chk("freeze_hold", red[14], 16'h3186);
        chk("freeze_no_timeout", timeout, 1'b0);
        win = 1'b0;
        step(2);                                    // edge 81
        chk("resume_pre_shift", red[14], 16'h3186);
        step(1);                                    // edge 82
        chk("resume_shift", red[14], 16'h630C);

        level = 2'd0;
        step(1);                                    // edge 83
        level = 2'd1;
        step(1);                                    // edge 84
        chk("lvl0_row14_empty", red[14], 16'h0000);
        chk("lvl0_row13_seed", red[13], 16'h618C);
        step(1);                                    // edge 85
        chk("lvl1_row14_seed", red[14], 16'h618C);
        chk("lvl1_row13_lane1", red[13], 16'h30C6);
        chk("lvl1_row1_lane8", red[1], 16'h8C61);
        chk("lvl1_row12_empty", red[12], 16'h0000);
        chk("lvl1_row15_empty", red[15], 16'h0000);

        lane_rand = '0;
        step(24);                                   // edge 109
        movement = 1'b1;
        step(1);                                    // edge 110
        movement = 1'b0;
        step(23);                                   // edge 133
        chk("full_revolution", red[14], 16'h618C);
        step(3);                                    // edge 136
        chk("shift17_direction", red[14], rev_exp);

        level = 2'd3;
        step(4);                                    // edge 140
        chk("pause_hold", red[14], rev_exp);
        chk("pause_no_timeout", timeout, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_field.md
Name: obstacle_field

Overview:
Parametrised obstacle-lane generator for the LED-matrix crossing game. It drives the red plane: ROWS x COLS, row 0 at the bottom, bit 0 at the right.
- LANES circular shift-register lanes, each with a seeded pattern, a latched direction and a latched speed.
- A per-level table maps lanes onto matrix rows.
- Idle-timeout kill forces the full matrix on.
- Sits between the LFSR block and the LED driver, alongside the player/green control.

Parameters:
ROWS, 16, matrix rows (≤16; lane-row map table covers rows 0..15)
COLS, 16, matrix columns / lane width
LANES, 10, number of obstacle lanes (≤ ROWS)
DIV_W, 32, tick/idle counter width
FAST_BASE, 10000000, fast-tick period at hardest level (cycles)
SLOW_BASE, 15000000, slow-tick period at hardest level (cycles)
LEVEL_STEP, 5000000, period added per level below hardest
IDLE_LIMIT, 500000000, idle cycles before kill (10 s at 50 MHz)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
level  in  2  0 easy, 1 medium, 2 hard, 3 pause
lane_rand  in  LANES  per-lane random bit from LFSR (1 = fast + left)
movement  in  1  player moved this cycle
win  in  1  game won (freeze)
loss  in  1  game lost (freeze)
red  out  ROWS x COLS  packed [ROWS-1:0][COLS-1:0] obstacle plane
timeout  out  1  idle kill active

Behaviour:
- Reset: `red` = 0, `timeout` = 0, tick counters = 0, idle counter = 0, `level_q` = `level`.
  - Lane i reg = `OBST_BASE` (16'hC318, low COLS bits) rotated right by i+1.
  - `dir[i]` and `spd[i]` load from `lane_rand[i]`.
- Tick generators (fast, slow):
  - Each counter runs 0..P-1; it pulses tick for one cycle when count == P-1, then wraps to 0.
  - Fast period = FAST_BASE + (2-level)*LEVEL_STEP. Slow period = SLOW_BASE + (2-level)*LEVEL_STEP.
- Lane shift:
  - On its tick (`spd[i]` = 1 → fast, 0 → slow), lane i rotates by one position.
  - `dir[i]` = 1 → rotate toward MSB; `dir[i]` = 0 → rotate toward LSB.
  - Rotation is circular; no bits are lost.
- Freeze: while `win` or `loss` is high, lanes hold, tick counters hold and the idle counter holds.
- Level change: in the cycle where `level` != `level_q`:
  - lanes reseed, both tick counters clear, `dir`/`spd` reload from `lane_rand`, idle counter clears.
  - `level_q` updates.
- Pause (`level` = 3): lanes, tick counters, idle counter and `red` all hold.
- Output register: `red` updates every non-reset, non-pause cycle from the current lane regs, so there is one cycle of latency from lane shift to `red`. Rows not listed for a level are 0.
  - level 0: `red[13-2k]` = lane k, k = 0..6.
  - level 1: `red[14,13,11,9,7,6,4,2,1]` = lanes 0..8.
  - level 2: `red[14,13,11,9,7,6,4,3,2,1]` = lanes 0..9.
- Idle kill:
  - Counter increments each cycle with !`movement` & !`win` & !`loss` & `level` != 3, saturating at IDLE_LIMIT.
  - At IDLE_LIMIT, `timeout` = 1 and `red` = all ones from the next cycle, overriding everything.
  - `movement` = 1 clears counter and `timeout` that cycle; `red` resumes normal mapping next cycle.
- Simultaneous events:
  - reset > level change > freeze > tick.
  - `movement` and a limit hit in the same cycle → `movement` wins, no kill.

Optional Feature:
`OBST_REVERSE_EN`: each lane keeps a revolution counter (clog2(COLS) bits). When it completes COLS shifts, `dir[i]` resamples from `lane_rand[i]` and the counter wraps. Counters clear on reset or level change. Without the macro, direction stays latched until reset or level change.

Decomposition:
- Package `obst_pkg` holds:
  - `level_t` enum (EASY, MEDIUM, HARD, PAUSE);
  - `OBST_BASE`;
  - lane-row map table, 3 x 16 entries of lane index or `NO_LANE`;
  - period function `tick_period(level, base, step)`.
- Sub-module `obst_lane`: one rotating register with seed, dir, enable, reseed and optional revolution counter. Generate LANES instances.

Test Plan:
1. Params FAST_BASE=2, SLOW_BASE=3, LEVEL_STEP=1, IDLE_LIMIT=50; level=0, `lane_rand`=0; reset 5 cycles → first posedge after release `red[13]`=16'h618C, `red[0]`=0, `red[15]`=0; 5 cycles later `red[13]`=16'h30C6.
2. `lane_rand[0]`=1, level=2 → `red[14]` rotates left every 2 cycles: 16'h618C → 16'hC318 → 16'h8631.
3. No movement for 50 cycles → `timeout`=1, `red`=all 16'hFFFF; pulse `movement` → next cycle `timeout`=0, mapping restored.
4. Assert `win` mid-game for 20 cycles → `red` constant, `timeout` stays 0; release → shifting resumes from the frozen pattern.
5. Switch level 0→1 → lanes reseeded; `red[14]`=lane 0 seed 16'h618C; `red[15]`=0.
6. `OBST_REVERSE_EN` defined, `lane_rand[0]` toggled after 16 shifts → lane 0 direction reverses on the 17th shift; macro undefined → no reversal.
